// File: rtl/music_note_synth.sv
// rtl/music_note_synth.sv - phase-accumulator note synth with waveform select, attack/release envelope and one-entry note queue
// Optional GLIDE_EN: slew the increment toward a new note instead of release-then-attack.
module music_note_synth #(
  parameter int DATA_W       = 12,
  parameter int ACC_W        = 24,
  parameter int ENV_W        = 8,
  parameter int SAMPLE_DIV   = 5000,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 16,
  parameter int GLIDE_STEP   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [4:0]        note_idx,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              active
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  localparam logic [4:0] REST = 5'd31;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]        phase_q, phase_d, inc_q, inc_d;
  logic [ENV_W-1:0]        env_q, env_d;
  logic [4:0]              cur_q, cur_d, pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0]       sample_q, sample_d;
  logic                    sample_valid_q, sample_valid_d;
`ifdef GLIDE_EN
  logic [ACC_W-1:0]        tgt_q, tgt_d;
`endif

  logic                    tick, accept;
  logic [DATA_W-1:0]       wave, tri_t;
  logic [DATA_W+ENV_W-1:0] prod;
  logic [ENV_W:0]          env_sum;

  // Values are round(220 * 2^(n/12) * 2^24 / 20000): a 24-bit accumulator at a 20 kHz tick.
  function automatic logic [ACC_W-1:0] inc_rom(input logic [4:0] n);
    logic [23:0] v;
    case (n)
      5'd0:  v = 24'd184549;   5'd1:  v = 24'd195523;   5'd2:  v = 24'd207150;
      5'd3:  v = 24'd219467;   5'd4:  v = 24'd232518;   5'd5:  v = 24'd246344;
      5'd6:  v = 24'd260992;   5'd7:  v = 24'd276512;   5'd8:  v = 24'd292954;
      5'd9:  v = 24'd310374;   5'd10: v = 24'd328830;   5'd11: v = 24'd348383;
      5'd12: v = 24'd369099;   5'd13: v = 24'd391047;   5'd14: v = 24'd414299;
      5'd15: v = 24'd438935;   5'd16: v = 24'd465035;   5'd17: v = 24'd492688;
      5'd18: v = 24'd521984;   5'd19: v = 24'd553023;   5'd20: v = 24'd585908;
      5'd21: v = 24'd620748;   5'd22: v = 24'd657659;   5'd23: v = 24'd696766;
      5'd24: v = 24'd738198;   5'd25: v = 24'd782093;   5'd26: v = 24'd828599;
      5'd27: v = 24'd877870;   5'd28: v = 24'd930071;   5'd29: v = 24'd985375;
      5'd30: v = 24'd1043969;
      default: v = 24'd0;
    endcase
    return ACC_W'(v);
  endfunction

  assign tick       = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign note_ready = !pend_vld_q;
  assign accept     = note_valid && note_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = tick ? '0 : cnt_q + CNT_W'(1);
    phase_d        = phase_q;
    inc_d          = inc_q;
    env_d          = env_q;
    cur_d          = cur_q;
    pend_d         = pend_q;
    pend_vld_d     = pend_vld_q;
    sample_d       = sample_q;
    sample_valid_d = tick;
`ifdef GLIDE_EN
    tgt_d          = tgt_q;
`endif
    wave           = '0;
    tri_t          = '0;
    prod           = '0;
    env_sum        = '0;

    // Tick effects first; note acceptance below sees the post-tick state.
    if (tick) begin
      if (state_q != IDLE) phase_d = phase_q + inc_q;
      case (state_q)
        ATTACK: begin
          env_sum = {1'b0, env_q} + (ENV_W+1)'(ATTACK_STEP);
          if (env_sum >= {1'b0, ENV_MAX}) begin
            env_d   = ENV_MAX;
            state_d = SUSTAIN;
          end else begin
            env_d = env_sum[ENV_W-1:0];
          end
        end
        RELEASE: begin
          env_d = ({1'b0, env_q} > (ENV_W+1)'(RELEASE_STEP)) ? env_q - ENV_W'(RELEASE_STEP) : '0;
          if (env_d == '0) begin
            pend_vld_d = 1'b0;
            if (pend_q == REST) begin
              state_d = IDLE;
            end else begin
              state_d = ATTACK;
              cur_d   = pend_q;
              inc_d   = inc_rom(pend_q);
              phase_d = '0;
`ifdef GLIDE_EN
              tgt_d   = inc_rom(pend_q);
`endif
            end
          end
        end
        default: ;
      endcase
`ifdef GLIDE_EN
      if (state_q == ATTACK || state_q == SUSTAIN) begin
        if (inc_q < tgt_q)
          inc_d = (tgt_q - inc_q > ACC_W'(GLIDE_STEP)) ? inc_q + ACC_W'(GLIDE_STEP) : tgt_q;
        else if (inc_q > tgt_q)
          inc_d = (inc_q - tgt_q > ACC_W'(GLIDE_STEP)) ? inc_q - ACC_W'(GLIDE_STEP) : tgt_q;
      end
`endif
      case (mode)
        2'd0: wave = phase_d[ACC_W-1] ? '0 : '1;
        2'd1: begin
          tri_t = phase_d[ACC_W-2 -: DATA_W];
          wave  = phase_d[ACC_W-1] ? ~tri_t : tri_t;
        end
        2'd2: wave = phase_d[ACC_W-1 -: DATA_W];
        default: wave = (phase_d[ACC_W-1 -: 2] == 2'b00) ? '1 : '0;
      endcase
      prod     = {{ENV_W{1'b0}}, wave} * {{DATA_W{1'b0}}, env_d};
      sample_d = (state_d == IDLE) ? '0 : DATA_W'(prod >> ENV_W);
    end

    if (accept) begin
      case (state_d)
        IDLE: begin
          if (note_idx != REST) begin
            state_d = ATTACK;
            cur_d   = note_idx;
            inc_d   = inc_rom(note_idx);
            phase_d = '0;
`ifdef GLIDE_EN
            tgt_d   = inc_rom(note_idx);
`endif
          end
        end
        ATTACK, SUSTAIN: begin
          if (note_idx != cur_d) begin
`ifdef GLIDE_EN
            if (note_idx != REST) begin
              tgt_d = inc_rom(note_idx);
              cur_d = note_idx;
            end else begin
              pend_d     = note_idx;
              pend_vld_d = 1'b1;
              state_d    = RELEASE;
            end
`else
            pend_d     = note_idx;
            pend_vld_d = 1'b1;
            state_d    = RELEASE;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      phase_q        <= '0;
      inc_q          <= '0;
      env_q          <= '0;
      cur_q          <= '0;
      pend_q         <= '0;
      pend_vld_q     <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
`ifdef GLIDE_EN
      tgt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      inc_q          <= inc_d;
      env_q          <= env_d;
      cur_q          <= cur_d;
      pend_q         <= pend_d;
      pend_vld_q     <= pend_vld_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
`ifdef GLIDE_EN
      tgt_q          <= tgt_d;
`endif
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign active       = (state_q != IDLE);

endmodule

// File: tb/tb_music_note_synth.sv
// tb/tb_music_note_synth.sv - directed vector table plus randomized run against a behavioural note-synth model
module tb_music_note_synth;

  localparam int DIV = 4;
  localparam int AS  = 255;
  localparam int RS  = 48;
  localparam int GS  = 64;
  localparam longint ONE   = 16777216;
  localparam longint HALF  = 8388608;
  localparam longint QUART = 4194304;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_SUSTAIN = 2, S_RELEASE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [4:0]  note_idx = '0;
  logic [1:0]  mode = '0;
  logic [11:0] sample;
  logic        sample_valid;
  logic        active;

  music_note_synth #(
    .DATA_W(12), .ACC_W(24), .ENV_W(8), .SAMPLE_DIV(DIV),
    .ATTACK_STEP(AS), .RELEASE_STEP(RS), .GLIDE_STEP(GS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
    .note_idx(note_idx), .mode(mode), .sample(sample), .sample_valid(sample_valid),
    .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  longint inc_tbl [32];

  typedef struct {
    int st; longint phase; longint inc; longint tgt;
    int env; int cur; int pend; int cnt; int smp; bit sv;
  } model_t;

  model_t m;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.st = S_IDLE; r.phase = 0; r.inc = 0; r.tgt = 0; r.env = 0;
    r.cur = 0; r.pend = -1; r.cnt = 0; r.smp = 0; r.sv = 1'b0;
    return r;
  endfunction

  function automatic int wave_of(longint p, int md);
    int t;
    case (md)
      0: return (p < HALF) ? 4095 : 0;
      1: begin
        t = int'((p % HALF) / 2048);
        return (p < HALF) ? t : 4095 - t;
      end
      2: return int'(p / 4096);
      default: return (p < QUART) ? 4095 : 0;
    endcase
  endfunction

  function automatic model_t model_next(model_t mi, bit v, int n, int md);
    model_t r = mi;
    bit tick = (mi.cnt == DIV - 1);
    r.cnt = tick ? 0 : mi.cnt + 1;
    r.sv  = tick;
    if (tick) begin
      if (mi.st != S_IDLE) r.phase = (mi.phase + mi.inc) % ONE;
      if (mi.st == S_ATTACK) begin
        r.env = (mi.env + AS > 255) ? 255 : mi.env + AS;
        if (r.env == 255) r.st = S_SUSTAIN;
      end else if (mi.st == S_RELEASE) begin
        r.env = (mi.env > RS) ? mi.env - RS : 0;
        if (r.env == 0) begin
          if (mi.pend == 31) r.st = S_IDLE;
          else begin
            r.st = S_ATTACK; r.cur = mi.pend; r.inc = inc_tbl[mi.pend];
            r.tgt = r.inc; r.phase = 0;
          end
          r.pend = -1;
        end
      end
`ifdef GLIDE_EN
      if (mi.st == S_ATTACK || mi.st == S_SUSTAIN) begin
        if (mi.inc < mi.tgt) r.inc = (mi.tgt - mi.inc > GS) ? mi.inc + GS : mi.tgt;
        else if (mi.inc > mi.tgt) r.inc = (mi.inc - mi.tgt > GS) ? mi.inc - GS : mi.tgt;
      end
`endif
      r.smp = (r.st == S_IDLE) ? 0 : (wave_of(r.phase, md) * r.env) / 256;
    end
    if (v && mi.pend < 0) begin
      if (r.st == S_IDLE) begin
        if (n != 31) begin
          r.st = S_ATTACK; r.cur = n; r.inc = inc_tbl[n]; r.tgt = r.inc; r.phase = 0;
        end
      end else if ((r.st == S_ATTACK || r.st == S_SUSTAIN) && n != r.cur) begin
`ifdef GLIDE_EN
        if (n != 31) begin
          r.tgt = inc_tbl[n]; r.cur = n;
        end else begin
          r.pend = n; r.st = S_RELEASE;
        end
`else
        r.pend = n; r.st = S_RELEASE;
`endif
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, note_valid, int'(note_idx), int'(mode));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sample", sample, m.smp);
      check("model_sample_valid", sample_valid, m.sv);
      check("model_note_ready", note_ready, m.pend < 0);
      check("model_active", active, m.st != S_IDLE);
    end
  end

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_wait: no sample_valid within %0d clks", 4 * DIV);
    end
  endtask

  typedef struct {
    bit v; int idx; int md; int ticks;
    bit chk_s; int exp_s; bit exp_rdy; bit exp_act;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, int idx, int md, int ticks, bit chk_s, int exp_s, bit rdy, bit act);
    vec_t x;
    x.v = v; x.idx = idx; x.md = md; x.ticks = ticks;
    x.chk_s = chk_s; x.exp_s = exp_s; x.exp_rdy = rdy; x.exp_act = act;
    return x;
  endfunction

  function automatic int saw_exp(longint k, longint inc, int env);
    return int'((((k * inc) % ONE) / 4096) * env / 256);
  endfunction

  initial begin
    bit ok;
    int wraps;
    int prev;
    for (int n = 0; n < 31; n++)
      inc_tbl[n] = longint'($rtoi(220.0 * (2.0 ** (n / 12.0)) * 16777216.0 / 20000.0 + 0.5));
    inc_tbl[31] = 0;

    vecs.push_back(mk(1, 12, 2, 1, 1, saw_exp(1, 369099, 255), 1, 1));
    vecs.push_back(mk(0, 12, 2, 1, 1, saw_exp(2, 369099, 255), 1, 1));
    vecs.push_back(mk(0, 12, 2, 1, 1, saw_exp(3, 369099, 255), 1, 1));
    vecs.push_back(mk(0, 12, 0, 1, 1, 4095 * 255 / 256, 1, 1));
    vecs.push_back(mk(0, 12, 3, 1, 1, 4095 * 255 / 256, 1, 1));
    vecs.push_back(mk(0, 12, 1, 1, 1, ((6 * 369099) / 2048) * 255 / 256, 1, 1));
    vecs.push_back(mk(1, 31, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 2, 6, 1, 0, 1, 0));
    vecs.push_back(mk(1, 31, 2, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 2, 1, 1, saw_exp(1, 184549, 255), 1, 1));
`ifdef GLIDE_EN
    vecs.push_back(mk(1, 12, 2, 0, 1, saw_exp(1, 184549, 255), 1, 1));
    vecs.push_back(mk(0, 0, 2, 5, 0, 0, 1, 1));
`else
    vecs.push_back(mk(1, 12, 2, 0, 1, saw_exp(1, 184549, 255), 0, 1));
    vecs.push_back(mk(0, 0, 2, 5, 1, saw_exp(6, 184549, 15), 0, 1));
    vecs.push_back(mk(0, 0, 2, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 2, 1, 1, saw_exp(1, 369099, 255), 1, 1));
`endif

    repeat (3) @(negedge clk);
    check("reset_sample", sample, 0);
    check("reset_sample_valid", sample_valid, 0);
    check("reset_note_ready", note_ready, 1);
    check("reset_active", active, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    foreach (vecs[i]) begin
      note_valid = vecs[i].v;
      note_idx   = 5'(vecs[i].idx);
      mode       = 2'(vecs[i].md);
      @(negedge clk);
      note_valid = 1'b0;
      for (int t = 0; t < vecs[i].ticks; t++) wait_tick(ok);
      if (vecs[i].chk_s) check($sformatf("vec%0d_sample", i), sample, vecs[i].exp_s);
      check($sformatf("vec%0d_note_ready", i), note_ready, vecs[i].exp_rdy);
      check($sformatf("vec%0d_active", i), active, vecs[i].exp_act);
    end

    // Asynchronous reset while a note is sounding and sample_valid is high.
    wait_tick(ok);
    rst_n = 1'b0;
    #1;
    check("async_rst_sample", sample, 0);
    check("async_rst_sample_valid", sample_valid, 0);
    check("async_rst_note_ready", note_ready, 1);
    check("async_rst_active", active, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= DIV; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_tick%0d", i), sample_valid, (i == DIV) ? 1 : 0);
    end

    // Highest note in saw mode for 500 ticks: count phase wraps.
    note_valid = 1'b1; note_idx = 5'd30; mode = 2'd2;
    @(negedge clk);
    note_valid = 1'b0;
    wraps = 0;
    prev  = 0;
    for (int k = 1; k <= 500; k++) begin
      wait_tick(ok);
      if (k > 1 && int'(sample) < prev) wraps++;
      prev = int'(sample);
    end
    check("wrap_count", wraps, (500 * inc_tbl[30]) / ONE - inc_tbl[30] / ONE);

    for (int c = 0; c < 4000; c++) begin
      int r;
      note_valid = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0, 1: note_idx = 5'd31;
        2:    note_idx = 5'd0;
        3:    note_idx = 5'd12;
        4:    note_idx = 5'd30;
        default: note_idx = 5'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1;
    note_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
